conga_note_judge: RTL
=====================

// Module: conga_note_judge
// PURPOSE
//   Consumer of the song-position count from the conga counter. Walks a
//   note-chart ROM of ascending note times, compares each against song_pos,
//   pulses note_due, judges player hits (perfect/good/miss), and keeps
//   score and combo. Sits between the song counter, the chart ROM and the
//   display/score logic.
// PARAMETERS
//   ADDR_W       6        chart ROM address width (max 2**ADDR_W notes)
//   PERFECT_WIN  16'd4    |song_pos - note_time| <= this -> perfect
//   GOOD_WIN     16'd12   |song_pos - note_time| <= this -> good (GOOD_WIN >= PERFECT_WIN)
//   END_MARK     16'hFFFF chart entry marking end of song
// PORTS
//   clk          in   1        system clock, all logic on posedge
//   resetn       in   1        asynchronous active-low reset
//   start        in   1        pulse: clear score/combo, restart chart at address 0
//   song_pos     in   16       current song position from counter
//   hit          in   1        one-cycle player hit pulse (already debounced)
//   rom_addr     out  ADDR_W   chart ROM address
//   rom_data     in   16       note time; valid 1 cycle after rom_addr (synchronous ROM)
//   note_due     out  1        1-cycle pulse when song_pos first equals armed note_time
//   hit_perfect  out  1        1-cycle pulse, perfect judgement
//   hit_good     out  1        1-cycle pulse, good judgement
//   miss         out  1        1-cycle pulse, note passed unhit
//   score        out  16       accumulated score, saturating
//   combo        out  8        consecutive judged hits, saturating
//   busy         out  1        high in FETCH/LOAD/ARMED
//   done         out  1        high in DONE, held until start
// BEHAVIOUR
//   Reset (resetn=0, async): state=IDLE; rom_addr=0; score=0; combo=0;
//     note_time=0; all pulse outputs, busy, done = 0.
//   FSM: IDLE, FETCH, LOAD, ARMED, DONE.
//   - IDLE: start -> FETCH; rom_addr=0, score=0, combo=0.
//   - FETCH: rom_addr stable, 1 cycle -> LOAD.
//   - LOAD: note_time<=rom_data; rom_data==END_MARK -> DONE, else -> ARMED.
//   - ARMED: dist = |song_pos - note_time| (17-bit compare, no wrap).
//       hit && dist<=PERFECT_WIN: hit_perfect, score+=3, combo+=1 -> ADV
//       hit && dist<=GOOD_WIN:    hit_good,    score+=1, combo+=1 -> ADV
//       hit && song_pos < note_time-GOOD_WIN (saturate at 0): ignored, stay
//       song_pos > note_time+GOOD_WIN (17-bit sum): miss, combo=0 -> ADV
//       ADV: rom_addr+=1 -> FETCH; if rom_addr was 2**ADDR_W-1 -> DONE.
//   - DONE: done=1; outputs frozen; start -> FETCH as from IDLE.
//   - note_due: pulsed once per armed note, first ARMED cycle with
//     song_pos==note_time; flag cleared on LOAD.
//   - Judgement pulses registered, asserted the cycle after the deciding
//     edge; at most one of hit_perfect/hit_good/miss per cycle.
//   - hit and late condition same cycle: late wins (miss), hit dropped.
//   - hit outside ARMED: ignored.
//   - score saturates at 16'hFFFF; combo saturates at 8'd255.
//   - start in any state (incl. mid-ARMED) restarts at address 0 next cycle,
//     no judgement pulse for abandoned note; start has priority over hit.
//   - Latency start -> first ARMED: 3 cycles (FETCH, LOAD, ARMED).
// TESTING
//   1) Chart {100,200,FFFF}; hit at song_pos=100 and 203 -> hit_perfect, then
//      hit_perfect (dist 3); score=6, combo=2, done=1.
//   2) Chart {100,FFFF}; hit at song_pos=110 -> hit_good, score=1, combo=1.
//   3) Chart {100,150,FFFF}; no hit; song_pos sweeps to 113 -> miss at 113,
//      combo=0, then miss at 163; note_due pulses at 100 and 150 exactly once.
//   4) Chart {5,FFFF}; hit at song_pos=0 -> dist 5 -> hit_good (early bound
//      saturates at 0, no wrap).
//   5) Chart {100,...}; start pulsed at song_pos=95 in ARMED -> rom_addr=0,
//      score=0, no judgement pulse; resetn low mid-ARMED -> all outputs 0
//      immediately.
//   6) score preloaded near max by 0xFFFF/3 perfect hits -> score holds at
//      16'hFFFF; 300 consecutive hits -> combo holds at 255.

Source files
------------

// File: rtl/conga_note_judge.sv
`default_nettype none
// ============================================================================
// Module   : conga_note_judge
// Purpose  : Walks an ascending note-time chart held in a synchronous ROM.
//            Each note is compared against the song position. The module
//            announces when a note is due, judges player hits as perfect,
//            good or miss, and keeps a saturating score and combo count.
// Ports    : clk, resetn (async, active low)
//            start               restart chart at address 0, clear score/combo
//            song_pos[15:0]      current song position
//            hit                 one-cycle player hit pulse
//            rom_addr[ADDR_W-1:0], rom_data[15:0]  chart ROM (1-cycle read)
//            note_due, hit_perfect, hit_good, miss  registered 1-cycle pulses
//            score[15:0], combo[7:0]                saturating counters
//            busy (FETCH/LOAD/ARMED), done (chart finished, held)
// Revision : 1.0  initial release
// ============================================================================
module conga_note_judge #(
    parameter int          ADDR_W      = 6,
    parameter logic [15:0] PERFECT_WIN = 16'd4,
    parameter logic [15:0] GOOD_WIN    = 16'd12,
    parameter logic [15:0] END_MARK    = 16'hFFFF
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic [15:0]       song_pos,
    input  logic              hit,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    output logic              note_due,
    output logic              hit_perfect,
    output logic              hit_good,
    output logic              miss,
    output logic [15:0]       score,
    output logic [7:0]        combo,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] c_ST_IDLE  = 3'd0;
    localparam logic [2:0] c_ST_FETCH = 3'd1;
    localparam logic [2:0] c_ST_LOAD  = 3'd2;
    localparam logic [2:0] c_ST_ARMED = 3'd3;
    localparam logic [2:0] c_ST_DONE  = 3'd4;

    localparam logic [ADDR_W-1:0] c_ADDR_LAST = '1;
    localparam logic [ADDR_W-1:0] c_ADDR_ONE  = ADDR_W'(1);

    // ------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------
    logic [2:0]        r_state;
    logic [ADDR_W-1:0] r_addr;
    logic [15:0]       r_note_time;
    logic [15:0]       r_score;
    logic [7:0]        r_combo;
    logic              r_due_seen;
    logic              r_note_due;
    logic              r_hit_perfect;
    logic              r_hit_good;
    logic              r_miss;

    // ------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------
    logic [2:0]        w_state_nxt;
    logic [ADDR_W-1:0] w_addr_nxt;
    logic [15:0]       w_note_time_nxt;
    logic [15:0]       w_score_nxt;
    logic [7:0]        w_combo_nxt;
    logic              w_due_seen_nxt;
    logic              w_note_due_nxt;
    logic              w_hit_perfect_nxt;
    logic              w_hit_good_nxt;
    logic              w_miss_nxt;
    logic              w_adv;

    // ------------------------------------------------------------------
    // Timing window arithmetic. Everything is widened to 17 bits so a
    // note near 16'hFFFF cannot wrap its late limit back to a small value,
    // and a note near 0 cannot wrap its early side.
    // ------------------------------------------------------------------
    logic [16:0] w_pos_x;
    logic [16:0] w_note_x;
    logic [16:0] w_dist;
    logic [16:0] w_late_lim;
    logic        w_late;
    logic        w_in_perfect;
    logic        w_in_good;

    assign w_pos_x      = {1'b0, song_pos};
    assign w_note_x     = {1'b0, r_note_time};
    assign w_dist       = (w_pos_x >= w_note_x) ? (w_pos_x - w_note_x)
                                                : (w_note_x - w_pos_x);
    assign w_late_lim   = w_note_x + {1'b0, GOOD_WIN};
    assign w_late       = (w_pos_x > w_late_lim);
    assign w_in_perfect = (w_dist <= {1'b0, PERFECT_WIN});
    assign w_in_good    = (w_dist <= {1'b0, GOOD_WIN});

    // Saturating increments
    logic [16:0] w_score_p3;
    logic [16:0] w_score_p1;
    logic [15:0] w_score_add3;
    logic [15:0] w_score_add1;
    logic [7:0]  w_combo_inc;

    assign w_score_p3   = {1'b0, r_score} + 17'd3;
    assign w_score_p1   = {1'b0, r_score} + 17'd1;
    assign w_score_add3 = w_score_p3[16] ? 16'hFFFF : w_score_p3[15:0];
    assign w_score_add1 = w_score_p1[16] ? 16'hFFFF : w_score_p1[15:0];
    assign w_combo_inc  = (r_combo == 8'hFF) ? 8'hFF : (r_combo + 8'd1);

    // ------------------------------------------------------------------
    // Next-state / datapath decode
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt       = r_state;
        w_addr_nxt        = r_addr;
        w_note_time_nxt   = r_note_time;
        w_score_nxt       = r_score;
        w_combo_nxt       = r_combo;
        w_due_seen_nxt    = r_due_seen;
        w_note_due_nxt    = 1'b0;
        w_hit_perfect_nxt = 1'b0;
        w_hit_good_nxt    = 1'b0;
        w_miss_nxt        = 1'b0;
        w_adv             = 1'b0;

        if (start) begin
            // Restart wins over everything, including a hit on the note
            // currently armed; the abandoned note is never judged.
            w_state_nxt = c_ST_FETCH;
            w_addr_nxt  = '0;
            w_score_nxt = '0;
            w_combo_nxt = '0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                end
                c_ST_FETCH: begin
                    w_state_nxt = c_ST_LOAD;
                end
                c_ST_LOAD: begin
                    w_note_time_nxt = rom_data;
                    w_due_seen_nxt  = 1'b0;
                    w_state_nxt     = (rom_data == END_MARK) ? c_ST_DONE : c_ST_ARMED;
                end
                c_ST_ARMED: begin
                    if (!r_due_seen && (song_pos == r_note_time)) begin
                        w_note_due_nxt = 1'b1;
                        w_due_seen_nxt = 1'b1;
                    end
                    // Late check first: a hit arriving after the good window
                    // is dropped and the note is scored as a miss.
                    if (w_late) begin
                        w_miss_nxt  = 1'b1;
                        w_combo_nxt = '0;
                        w_adv       = 1'b1;
                    end else if (hit && w_in_perfect) begin
                        w_hit_perfect_nxt = 1'b1;
                        w_score_nxt       = w_score_add3;
                        w_combo_nxt       = w_combo_inc;
                        w_adv             = 1'b1;
                    end else if (hit && w_in_good) begin
                        w_hit_good_nxt = 1'b1;
                        w_score_nxt    = w_score_add1;
                        w_combo_nxt    = w_combo_inc;
                        w_adv          = 1'b1;
                    end
                    // Any remaining hit is early and simply ignored.

                    if (w_adv) begin
                        if (r_addr == c_ADDR_LAST) begin
                            w_state_nxt = c_ST_DONE;
                        end else begin
                            w_addr_nxt  = r_addr + c_ADDR_ONE;
                            w_state_nxt = c_ST_FETCH;
                        end
                    end
                end
                c_ST_DONE: begin
                end
                default: begin
                    w_state_nxt = c_ST_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state       <= c_ST_IDLE;
            r_addr        <= '0;
            r_note_time   <= '0;
            r_score       <= '0;
            r_combo       <= '0;
            r_due_seen    <= 1'b0;
            r_note_due    <= 1'b0;
            r_hit_perfect <= 1'b0;
            r_hit_good    <= 1'b0;
            r_miss        <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_addr        <= w_addr_nxt;
            r_note_time   <= w_note_time_nxt;
            r_score       <= w_score_nxt;
            r_combo       <= w_combo_nxt;
            r_due_seen    <= w_due_seen_nxt;
            r_note_due    <= w_note_due_nxt;
            r_hit_perfect <= w_hit_perfect_nxt;
            r_hit_good    <= w_hit_good_nxt;
            r_miss        <= w_miss_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign rom_addr    = r_addr;
    assign note_due    = r_note_due;
    assign hit_perfect = r_hit_perfect;
    assign hit_good    = r_hit_good;
    assign miss        = r_miss;
    assign score       = r_score;
    assign combo       = r_combo;
    assign busy        = (r_state == c_ST_FETCH) || (r_state == c_ST_LOAD) ||
                         (r_state == c_ST_ARMED);
    assign done        = (r_state == c_ST_DONE);

endmodule
`default_nettype wire
